// File: rtl/upc_add_sub_4_pkg.sv
// -----------------------------------------------------------------------------
// upc_add_sub_4_pkg
//   Shared constants for the registered add/subtract leaf.
//   - OP_ADD / OP_SUB : encodings of the mode input s
//   - DEFAULT_WIDTH   : default operand/result width
//   - ref_add_sub     : reference arithmetic, returns {carry_out, overflow, sum}
// -----------------------------------------------------------------------------
package upc_add_sub_4_pkg;

    localparam logic OP_ADD        = 1'b0;
    localparam logic OP_SUB        = 1'b1;
    localparam int   DEFAULT_WIDTH = 4;

    // Word-level reference for the default width: sum, raw carry-out and signed
    // overflow computed from plain arithmetic rather than from the cell chain.
    function automatic logic [DEFAULT_WIDTH+1:0] ref_add_sub(
        input logic [DEFAULT_WIDTH-1:0] op_a,
        input logic [DEFAULT_WIDTH-1:0] op_b,
        input logic                     op_s
    );
        logic [DEFAULT_WIDTH-1:0] b_cond;
        logic [DEFAULT_WIDTH:0]   full;
        logic                     ovf;
        b_cond = op_b ^ {DEFAULT_WIDTH{op_s}};
        full   = {1'b0, op_a} + {1'b0, b_cond} + {{DEFAULT_WIDTH{1'b0}}, op_s};
        // Signed overflow: operands (after conditioning) share a sign that the
        // result does not.
        ovf    = (op_a[DEFAULT_WIDTH-1] == b_cond[DEFAULT_WIDTH-1]) &&
                 (full[DEFAULT_WIDTH-1] != op_a[DEFAULT_WIDTH-1]);
        return {full[DEFAULT_WIDTH], ovf, full[DEFAULT_WIDTH-1:0]};
    endfunction

endpackage

// File: rtl/upc_add_sub_4_full_adder.sv
// -----------------------------------------------------------------------------
// upc_add_sub_4_full_adder
//   One-bit full-adder cell used to build the ripple-carry chain.
//   Ports:
//     a, b   : input  operand bits
//     cin    : input  carry in
//     sum    : output a ^ b ^ cin
//     cout   : output majority(a, b, cin)
// -----------------------------------------------------------------------------
module upc_add_sub_4_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/upc_add_sub_4.sv
// -----------------------------------------------------------------------------
// upc_add_sub_4
//   Registered two's-complement adder/subtractor, one-cycle latency, one op per
//   cycle, no enable. Built as a ripple chain of full-adder cells; subtraction
//   inverts B and injects the mode bit as the chain carry-in.
//   Ports:
//     clk  : input  rising-edge clock
//     rst  : input  synchronous active-high reset (clears r, c4, v)
//     r    : output registered result (WIDTH bits)
//     c4   : output registered raw carry-out of the MSB cell
//                   (in subtract mode 1 means no borrow, a >= b unsigned)
//     v    : output registered signed overflow
//     a, b : input  operands (WIDTH bits)
//     s    : input  mode, OP_ADD = a + b, OP_SUB = a - b
// -----------------------------------------------------------------------------
module upc_add_sub_4
    import upc_add_sub_4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] r,
    output logic             c4,
    output logic             v,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s
);

    logic [WIDTH-1:0] w_bi;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_c;
    logic             w_ovf;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    // Conditioning B with the mode bit plus carry-in of s gives a + ~b + 1.
    assign w_bi   = b ^ {WIDTH{s}};
    assign w_c[0] = s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        upc_add_sub_4_full_adder u_fa (
            .a    (a[i]),
            .b    (w_bi[i]),
            .cin  (w_c[i]),
            .sum  (w_sum[i]),
            .cout (w_c[i+1])
        );
    end

    // Carry into and out of the sign bit disagree exactly on signed overflow.
    assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_c[WIDTH];
            r_ovf  <= w_ovf;
        end
    end

    assign r  = r_sum;
    assign c4 = r_cout;
    assign v  = r_ovf;

endmodule

// File: tb/tb_upc_add_sub_4.sv
module tb_upc_add_sub_4;
    import upc_add_sub_4_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] r;
    logic       c4;
    logic       v;
    logic [3:0] a;
    logic [3:0] b;
    logic       s;

    int checks = 0;
    int errors = 0;

    upc_add_sub_4 #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .r   (r),
        .c4  (c4),
        .v   (v),
        .a   (a),
        .b   (b),
        .s   (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ta, input logic [3:0] tb, input logic ts);
        a = ta;
        b = tb;
        s = ts;
    endtask

    // Hand-computed directed vector: apply, one edge, compare.
    task automatic vec(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                       input logic ts, input logic [3:0] er, input logic ec, input logic ev);
        drive(ta, tb, ts);
        step();
        chk({tag, ".r"},  {4'h0, r},  {4'h0, er});
        chk({tag, ".c4"}, {7'h0, c4}, {7'h0, ec});
        chk({tag, ".v"},  {7'h0, v},  {7'h0, ev});
    endtask

    // Compare outputs against the package reference for given inputs.
    task automatic chk_model(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                             input logic ts);
        logic [5:0] m;
        m = ref_add_sub(ta, tb, ts);
        chk({tag, ".r"},  {4'h0, r},  {4'h0, m[3:0]});
        chk({tag, ".c4"}, {7'h0, c4}, {7'h0, m[5]});
        chk({tag, ".v"},  {7'h0, v},  {7'h0, m[4]});
    endtask

    logic [3:0] pa, pb;
    logic       ps;

    initial begin
        rst = 1'b1;
        drive(4'b1111, 4'b1111, OP_ADD);

        // Reset held two cycles dominates the inputs.
        step();
        chk("rst1.r",  {4'h0, r},  8'h00);
        chk("rst1.c4", {7'h0, c4}, 8'h00);
        chk("rst1.v",  {7'h0, v},  8'h00);
        step();
        chk("rst2.r",  {4'h0, r},  8'h00);
        chk("rst2.c4", {7'h0, c4}, 8'h00);
        chk("rst2.v",  {7'h0, v},  8'h00);
        rst = 1'b0;
        vec("rel",  4'b1111, 4'b1111, OP_ADD, 4'b1110, 1'b1, 1'b0);

        // Add set.
        vec("add0", 4'b0001, 4'b0001, OP_ADD, 4'b0010, 1'b0, 1'b0);
        vec("add1", 4'b0001, 4'b1001, OP_ADD, 4'b1010, 1'b0, 1'b0);
        vec("add2", 4'b1001, 4'b0011, OP_ADD, 4'b1100, 1'b0, 1'b0);
        // Subtract set.
        vec("sub0", 4'b0001, 4'b0001, OP_SUB, 4'b0000, 1'b1, 1'b0);
        vec("sub1", 4'b0001, 4'b1001, OP_SUB, 4'b1000, 1'b0, 1'b1);
        vec("sub2", 4'b1001, 4'b0011, OP_SUB, 4'b0110, 1'b1, 1'b1);
        // Add overflow.
        vec("aov0", 4'b0111, 4'b0001, OP_ADD, 4'b1000, 1'b0, 1'b1);
        vec("aov1", 4'b1000, 4'b1000, OP_ADD, 4'b0000, 1'b1, 1'b1);
        // Boundaries.
        vec("zsz",  4'b0000, 4'b0000, OP_SUB, 4'b0000, 1'b1, 1'b0);
        vec("asa",  4'b1010, 4'b1010, OP_SUB, 4'b0000, 1'b1, 1'b0);
        vec("add0b",4'b0110, 4'b0000, OP_ADD, 4'b0110, 1'b0, 1'b0);
        vec("subm", 4'b0000, 4'b1000, OP_SUB, 4'b1000, 1'b0, 1'b1);
        vec("subm2",4'b1000, 4'b1000, OP_SUB, 4'b0000, 1'b1, 1'b0);
        vec("subm3",4'b0111, 4'b1000, OP_SUB, 4'b1111, 1'b0, 1'b1);

        // Back-to-back: new inputs every cycle, each output tracks the previous edge.
        pa = 4'h3; pb = 4'h5; ps = 1'b0;
        drive(pa, pb, ps);
        for (int i = 0; i < 24; i++) begin
            step();
            chk_model($sformatf("b2b%0d", i), pa, pb, ps);
            pa = 4'(pa * 4'd5 + 4'd3);
            pb = 4'(pb + 4'd7);
            ps = ~ps ^ pa[0];
            drive(pa, pb, ps);
        end

        // Reset mid-stream discards the in-flight op, then the stream resumes.
        drive(4'b0111, 4'b0111, OP_ADD);
        step();
        chk("pre.r", {4'h0, r}, 8'h0E);
        rst = 1'b1;
        drive(4'b0101, 4'b0010, OP_ADD);
        step();
        chk("mid.r",  {4'h0, r},  8'h00);
        chk("mid.c4", {7'h0, c4}, 8'h00);
        chk("mid.v",  {7'h0, v},  8'h00);
        rst = 1'b0;
        vec("post", 4'b0101, 4'b0010, OP_SUB, 4'b0011, 1'b1, 1'b0);

        // Exhaustive sweep of a, b, s.
        for (int k = 0; k < 512; k++) begin
            pa = 4'(k >> 5);
            pb = 4'(k >> 1);
            ps = k[0];
            drive(pa, pb, ps);
            step();
            chk_model($sformatf("sw%0d", k), pa, pb, ps);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/upc_add_sub_4.md
Name: upc_add_sub_4

Overview:
- Registered 4-bit two's-complement adder/subtractor with carry-out and signed-overflow flags.
- Built as a ripple-carry chain of full-adder cells with XOR-conditioned B input; the subtract-mode bit is the carry-in.
- Used as the arithmetic leaf of the datapath.
- One clock, synchronous active-high reset, outputs registered with one-cycle latency.

Parameters:
- WIDTH, 4, operand/result width in bits. Flags refer to the MSB. All test values below assume 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- r  output  WIDTH  registered result
- c4  output  1  registered carry-out of the MSB cell
- v  output  1  registered signed overflow
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- s  input  1  mode: 0 = add (a+b), 1 = subtract (a-b)
- Positional order after clk, rst: r, c4, v, a, b, s.

Behaviour:
- Combinational core:
  - bi[i] = b[i] XOR s
  - carry c0 = s
  - sum[i] = a[i] ^ bi[i] ^ c[i]
  - c[i+1] = majority(a[i], bi[i], c[i])
- Result: sum = (a + (b XOR {WIDTH{s}}) + s) mod 2^WIDTH.
- Carry-out: c4 = c[WIDTH], the raw carry-out of the chain. In subtract mode, c4 = 1 means no borrow (a >= b unsigned). It is not inverted.
- Overflow: v = c[WIDTH] XOR c[WIDTH-1]. It is set when the signed result falls outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Registering: on each rising clk edge with rst = 0, r <= sum, c4 <= c[WIDTH], v <= overflow. Inputs are sampled every cycle.
- Handshake: none, no enable. Latency is exactly 1 cycle; throughput is 1 op per cycle.
- Reset: on a rising edge with rst = 1, r <= 0, c4 <= 0, v <= 0.
  - Reset dominates any concurrent input.
  - Reset asserted mid-stream discards the in-flight operation.
  - The first result after deassertion reflects the inputs sampled on the first edge with rst = 0.
- Before the first clock edge, outputs are undefined. The bench checks outputs only after reset.
- Boundary conditions:
  - a - a yields r = 0, c4 = 1, v = 0.
  - 0 - 0 yields r = 0, c4 = 1.
  - Adding 0 yields c4 = 0.
  - The most-negative operand in subtract mode (b = 1000) follows the same rules with no special casing.
- No latches. s changes take effect on the next edge, like data inputs.

Decomposition:
- Shared package:
  - localparams OP_ADD = 1'b0 and OP_SUB = 1'b1 for s
  - default WIDTH = 4
- Sub-module full_adder (a, b, cin -> sum, cout), instantiated WIDTH times via generate.
- The top level holds the XOR conditioning, the carry chain wiring, the overflow XOR and the output registers.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with a = 1111, b = 1111, s = 0 -> r = 0000, c4 = 0, v = 0. Deassert; the next edge produces 1110, c4 = 1, v = 0.
- Add set, one cycle after each apply:
  - a = 0001, b = 0001, s = 0 -> r = 0010, c4 = 0, v = 0
  - a = 0001, b = 1001, s = 0 -> r = 1010, c4 = 0, v = 0
  - a = 1001, b = 0011, s = 0 -> r = 1100, c4 = 0, v = 0
- Subtract set:
  - a = 0001, b = 0001, s = 1 -> r = 0000, c4 = 1, v = 0
  - a = 0001, b = 1001, s = 1 -> r = 1000, c4 = 0, v = 1
  - a = 1001, b = 0011, s = 1 -> r = 0110, c4 = 1, v = 1
- Add overflow: a = 0111, b = 0001, s = 0 -> r = 1000, c4 = 0, v = 1. Also a = 1000, b = 1000, s = 0 -> r = 0000, c4 = 1, v = 1.
- Back-to-back: change a, b, s every cycle. Each output equals the golden model of the inputs from the previous edge.
- Reset mid-stream: assert rst for one cycle during a stream -> outputs 0 that cycle, then resume.
- Exhaustive sweep: all 512 combinations of a, b, s, with r/c4/v compared against the reference formula above.
